// File: rtl/emit_multi_datapath.sv
// emit_multi_datapath: multi-channel valve emit counter.
// Each channel owns a down-counter that is loaded with a pour count and drives
// its valve while the count is non-zero. Decrements come from the per-channel
// ACK (manual mode) or a shared prescaled tick (auto mode).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cnt_ld     per-channel load strobe
//   cnt_clr    per-channel clear strobe (highest priority)
//   cnt_ACK    per-channel decrement acknowledge, used only when auto_mode=0
//   ld_val     per-channel load values, channel i at [i*CW +: CW]; 0 selects EMIT_CNT
//   auto_mode  1 = decrement on internal tick, 0 = decrement on cnt_ACK
//   out        registered valve drive per channel
//   eq_0       combinational, channel count == 0
//   done       registered one-cycle pulse when a channel drains 1 -> 0
//   busy       combinational OR of all out bits
//   tick       registered prescaler tick
module emit_multi_datapath #(
    parameter int unsigned CH       = 2,
    parameter int unsigned CW       = 4,
    parameter int unsigned EMIT_CNT = 5,
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned DIV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    cnt_ld,
    input  logic [CH-1:0]    cnt_clr,
    input  logic [CH-1:0]    cnt_ACK,
    input  logic [CH*CW-1:0] ld_val,
    input  logic             auto_mode,
    output logic [CH-1:0]    out,
    output logic [CH-1:0]    eq_0,
    output logic [CH-1:0]    done,
    output logic             busy,
    output logic             tick
);

    localparam logic [CW-1:0]    EMIT_VAL = CW'(EMIT_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [CH-1:0]         out_q, out_d;
    logic [CH-1:0]         done_q, done_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  tick_q, tick_d;
    logic [CH-1:0]         dec_ev;

    // The registered tick is shared by every channel in auto mode; ACKs are ignored then.
    assign dec_ev = auto_mode ? {CH{tick_q}} : cnt_ACK;

    // Prescaler only runs while auto mode is active and some valve is open,
    // so each pour (or mode switch back to auto) starts a fresh period.
    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if (auto_mode && busy) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Per-channel next state: clr > ld > dec > hold.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        done_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (cnt_clr[i]) begin
                cnt_d[i] = '0;
                out_d[i] = 1'b0;
            end else if (cnt_ld[i]) begin
                cnt_d[i] = (ld_val[i*CW +: CW] == '0) ? EMIT_VAL : ld_val[i*CW +: CW];
                out_d[i] = 1'b1;
            end else begin
                // Saturate at zero; only a real 1 -> 0 step produces done.
                if (dec_ev[i] && (cnt_q[i] != '0)) begin
                    cnt_d[i]  = cnt_q[i] - CW'(1);
                    done_d[i] = (cnt_q[i] == CW'(1));
                end
                out_d[i] = (cnt_d[i] != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= '0;
            done_q <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            done_q <= done_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        eq_0 = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            eq_0[i] = (cnt_q[i] == '0);
        end
    end

    assign busy = |out_q;
    assign out  = out_q;
    assign done = done_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_emit_multi_datapath.sv
// Directed bench for emit_multi_datapath (CH=2, CW=4, EMIT_CNT=5, TICK_DIV=4).
module tb_emit_multi_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cnt_ld, cnt_clr, cnt_ACK;
    logic [7:0] ld_val;
    logic       auto_mode;
    logic [1:0] out, eq_0, done;
    logic       busy, tick;

    int checks = 0;
    int passed = 0;

    emit_multi_datapath #(
        .CH(2), .CW(4), .EMIT_CNT(5), .TICK_DIV(4), .DIV_W(3)
    ) dut (
        .clk(clk), .rst(rst), .cnt_ld(cnt_ld), .cnt_clr(cnt_clr),
        .cnt_ACK(cnt_ACK), .ld_val(ld_val), .auto_mode(auto_mode),
        .out(out), .eq_0(eq_0), .done(done), .busy(busy), .tick(tick)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cnt_ld = '0; cnt_clr = '0; cnt_ACK = '0; ld_val = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; auto_mode = 1'b0; idle_inputs();
        step();
        checks++; if (out !== 2'b00) $display("FAIL reset_out got=%b exp=00", out); else passed++;
        checks++; if (eq_0 !== 2'b11) $display("FAIL reset_eq0 got=%b exp=11", eq_0); else passed++;
        checks++; if ({done, busy, tick} !== 4'b0) $display("FAIL reset_misc got=%b exp=0000", {done, busy, tick}); else passed++;
        rst = 1'b0;
        step();
        // Pour on ch0 with default count, two ACKs, then async reset mid-cycle.
        ld_val = 8'h00; cnt_ld = 2'b01;
        step();
        cnt_ld = '0;
        checks++; if (out !== 2'b01) $display("FAIL rstpour_load_out got=%b exp=01", out); else passed++;
        for (int k = 0; k < 2; k++) begin
            cnt_ACK = 2'b01;
            step();
            checks++; if (done !== 2'b00 || out !== 2'b01) $display("FAIL rstpour_ack%0d got out=%b done=%b exp out=01 done=00", k, out, done); else passed++;
        end
        cnt_ACK = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out !== 2'b00 || eq_0 !== 2'b11 || tick !== 1'b0) $display("FAIL rst_async got out=%b eq0=%b tick=%b exp 00/11/0", out, eq_0, tick); else passed++;
        step();
        checks++; if (done !== 2'b00) $display("FAIL rst_nodone got=%b exp=00", done); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_manual_drain();
        ld_val = 8'h00; cnt_ld = 2'b01;
        step();
        cnt_ld = '0;
        checks++; if (out !== 2'b01 || eq_0 !== 2'b10 || done !== 2'b00) $display("FAIL drain_load got out=%b eq0=%b done=%b exp 01/10/00", out, eq_0, done); else passed++;
        for (int k = 1; k <= 5; k++) begin
            cnt_ACK = 2'b01;
            step();
            checks++;
            if (out[0] !== (k != 5) || eq_0[0] !== (k == 5) || done[0] !== (k == 5))
                $display("FAIL drain_ack%0d got out=%b eq0=%b done=%b", k, out[0], eq_0[0], done[0]);
            else passed++;
        end
        cnt_ACK = '0;
        step();
        checks++; if (done !== 2'b00) $display("FAIL drain_done_width got=%b exp=00", done); else passed++;
        cnt_ACK = 2'b01;
        step();
        cnt_ACK = '0;
        checks++; if (eq_0[0] !== 1'b1 || done !== 2'b00 || out !== 2'b00) $display("FAIL drain_saturate got eq0=%b done=%b out=%b exp 1/00/00", eq_0[0], done, out); else passed++;
    endtask

    task automatic test_priority();
        ld_val = 8'h30; cnt_ld = 2'b10; cnt_ACK = 2'b10;
        step();
        idle_inputs();
        checks++; if (out !== 2'b10) $display("FAIL prio_ld_ack_out got=%b exp=10", out); else passed++;
        // Count must be 3: two ACKs leave it non-zero, the third drains it.
        for (int k = 1; k <= 3; k++) begin
            cnt_ACK = 2'b10;
            step();
            checks++;
            if (eq_0[1] !== (k == 3) || done[1] !== (k == 3))
                $display("FAIL prio_ack%0d got eq0=%b done=%b exp %b/%b", k, eq_0[1], done[1], (k == 3), (k == 3));
            else passed++;
        end
        cnt_ACK = '0;
        ld_val = 8'h30; cnt_ld = 2'b10;
        step();
        cnt_clr = 2'b10; cnt_ld = 2'b10;
        step();
        idle_inputs();
        checks++; if (out !== 2'b00 || eq_0 !== 2'b11 || done !== 2'b00) $display("FAIL prio_clr_ld got out=%b eq0=%b done=%b exp 00/11/00", out, eq_0, done); else passed++;
    endtask

    task automatic test_auto();
        logic [1:0] exp_out, exp_done;
        logic       exp_tick;
        auto_mode = 1'b1;
        ld_val = 8'h32; cnt_ld = 2'b11; cnt_ACK = 2'b11;
        step();
        cnt_ld = '0;  // ACKs stay asserted and must be ignored
        checks++; if (out !== 2'b11 || tick !== 1'b0) $display("FAIL auto_load got out=%b tick=%b exp 11/0", out, tick); else passed++;
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_tick = (k == 4) || (k == 8) || (k == 12);
            exp_out  = {(k < 13), (k < 9)};
            exp_done = {(k == 13), (k == 9)};
            checks++;
            if (tick !== exp_tick || out !== exp_out || done !== exp_done || busy !== (k < 13))
                $display("FAIL auto_cyc%0d got tick=%b out=%b done=%b busy=%b exp %b/%b/%b/%b",
                         k, tick, out, done, busy, exp_tick, exp_out, exp_done, (k < 13));
            else passed++;
        end
        auto_mode = 1'b0; cnt_ACK = '0;
    endtask

    task automatic test_independence();
        ld_val = 8'h54; cnt_ld = 2'b11;
        step();
        cnt_ld = '0;
        cnt_ACK = 2'b01;
        step();
        cnt_ACK = 2'b01; cnt_clr = 2'b10;
        step();
        cnt_clr = '0;
        checks++; if (out !== 2'b01 || eq_0 !== 2'b10 || done !== 2'b00) $display("FAIL indep_clr got out=%b eq0=%b done=%b exp 01/10/00", out, eq_0, done); else passed++;
        for (int k = 3; k <= 4; k++) begin
            cnt_ACK = 2'b01;
            step();
            checks++;
            if (done !== {1'b0, (k == 4)} || out[0] !== (k != 4))
                $display("FAIL indep_ack%0d got done=%b out=%b", k, done, out);
            else passed++;
        end
        cnt_ACK = '0;
        step();
    endtask

    task automatic test_reload();
        ld_val = 8'h04; cnt_ld = 2'b01;
        step();
        cnt_ld = '0;
        for (int k = 0; k < 2; k++) begin
            cnt_ACK = 2'b01;
            step();
        end
        cnt_ACK = '0;
        ld_val = 8'h07; cnt_ld = 2'b01;
        step();
        cnt_ld = '0;
        checks++; if (out !== 2'b01 || done !== 2'b00) $display("FAIL reload got out=%b done=%b exp 01/00", out, done); else passed++;
        // Count must be 7 after reload.
        for (int k = 1; k <= 7; k++) begin
            cnt_ACK = 2'b01;
            step();
            checks++;
            if (eq_0[0] !== (k == 7) || done[0] !== (k == 7))
                $display("FAIL reload_ack%0d got eq0=%b done=%b", k, eq_0[0], done[0]);
            else passed++;
        end
        cnt_ACK = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_manual_drain();
        test_priority();
        test_auto();
        test_independence();
        test_reload();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
